// File: rtl/approx_mul_arbiter_pkg.sv
// Shared constants and types for the two-requester approximate multiplier.
// Holds the default truncation width, the compensation bit positions and the stage-valid record.
package approx_mul_arbiter_pkg;

  localparam int TRUNC_DEFAULT = 10;

  // Bit positions of the approximate product that receive the compensation term.
  localparam int COMP_BIT_A = 11;
  localparam int COMP_BIT_B = 17;

  typedef struct packed {
    logic s1;
    logic s2;
  } stage_valid_t;

endpackage

// File: rtl/approx_mul32_core.sv
// Combinational 32x32 multiplier that returns either the exact 64-bit product
// or a truncated-x approximation with a small compensation term.
module approx_mul32_core
  import approx_mul_arbiter_pkg::*;
#(
  parameter int TRUNC = TRUNC_DEFAULT
) (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        exact,
  output logic [63:0] z
);

  logic [63:0] x_hi;
  logic [63:0] approx_prod;
  logic [63:0] comp;
  logic [63:0] exact_prod;

  always_comb begin
    x_hi        = 64'(x >> TRUNC);
    approx_prod = (64'(y) * x_hi) << TRUNC;
    exact_prod  = 64'(x) * 64'(y);
    // Compensation restores part of the mass lost by dropping the low x bits.
    comp             = '0;
    comp[COMP_BIT_A] = &{x[1:0], y[11:10]};
    comp[COMP_BIT_B] = &{x[3:2], y[14:13]};
    z = exact ? exact_prod : (approx_prod + comp);
  end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter for two multiply requesters feeding a two-stage
// pipeline: S1 holds the granted operands, S2 holds the registered product.
module approx_mul_arbiter
  import approx_mul_arbiter_pkg::*;
#(
  parameter int TRUNC = TRUNC_DEFAULT,
  parameter int NREQ  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [31:0]     req_x0,
  input  logic [31:0]     req_y0,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_y1,
  input  logic [NREQ-1:0] req_exact,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_z,
  output logic            out_id,
  output logic            busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the same port's data, only on valid,
  // the priority pointer and pipeline occupancy.

  stage_valid_t stv_q, stv_d;
  logic [31:0]  s1_x_q, s1_y_q;
  logic         s1_exact_q, s1_id_q;
  logic [63:0]  s2_z_q;
  logic         s2_id_q;
  logic         ptr_q;

  logic         s2_can_load, s1_advance, s1_can_load;
  logic         win_id, grant;
  logic [31:0]  sel_x, sel_y;
  logic         sel_exact;
  logic [63:0]  core_z;

  always_comb begin
    s2_can_load = !stv_q.s2 || out_ready;
    s1_advance  = stv_q.s1 && s2_can_load;
    s1_can_load = !stv_q.s1 || s1_advance;

    // With a single valid requester it wins outright; otherwise the pointer decides.
    win_id = (req_valid[0] && req_valid[1]) ? ptr_q : req_valid[1];
    grant  = (|req_valid) && s1_can_load && rst_n;

    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;

    sel_x     = win_id ? req_x1 : req_x0;
    sel_y     = win_id ? req_y1 : req_y0;
    sel_exact = req_exact[win_id];

    stv_d.s1 = grant || (stv_q.s1 && !s1_advance);
    stv_d.s2 = s1_advance || (stv_q.s2 && !out_ready);
  end

  approx_mul32_core #(
    .TRUNC(TRUNC)
  ) u_core (
    .x    (s1_x_q),
    .y    (s1_y_q),
    .exact(s1_exact_q),
    .z    (core_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stv_q      <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_exact_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_z_q     <= '0;
      s2_id_q    <= 1'b0;
      ptr_q      <= 1'b0;
    end else begin
      stv_q <= stv_d;
      if (grant) begin
        s1_x_q     <= sel_x;
        s1_y_q     <= sel_y;
        s1_exact_q <= sel_exact;
        s1_id_q    <= win_id;
        ptr_q      <= ~win_id;
      end
      if (s1_advance) begin
        s2_z_q  <= core_z;
        s2_id_q <= s1_id_q;
      end
    end
  end

  assign out_valid = stv_q.s2;
  assign out_z     = s2_z_q;
  assign out_id    = s2_id_q;
  assign busy      = stv_q.s1 || stv_q.s2;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Bench for approx_mul_arbiter: directed latency/arbitration/backpressure/reset
// scenarios followed by a long randomized run against an arithmetic reference.
module tb_approx_mul_arbiter;
  import approx_mul_arbiter_pkg::*;

  localparam int TRUNC = TRUNC_DEFAULT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_exact = '0;
  logic [31:0] req_x[2];
  logic [31:0] req_y[2];
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_z;
  logic        out_id;
  logic        busy;

  approx_mul_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x0   (req_x[0]),
    .req_y0   (req_y[0]),
    .req_x1   (req_x[1]),
    .req_y1   (req_y[1]),
    .req_exact(req_exact),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z),
    .out_id   (out_id),
    .busy     (busy)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic [64:0] exp_q[$];
  logic        ptr_m = 1'b0;
  logic [1:0]  acc;
  logic        lo_v, lo_id;
  logic [63:0] lo_z;
  logic        hold_valid = 1'b0;
  logic        hold_id;
  logic [63:0] hold_z;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference product computed with plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic ex);
    longint unsigned xl, yl, scale, r;
    xl = x;
    yl = y;
    if (ex) return xl * yl;
    scale = 64'd1 << TRUNC;
    r = yl * (xl / scale) * scale;
    if ((xl % 4) == 3 && ((yl / 1024) % 4) == 3) r = r + 2048;
    if (((xl / 4) % 4) == 3 && ((yl / 8192) % 4) == 3) r = r + 131072;
    return r;
  endfunction

  // Called at the falling edge: everything seen here commits at the next rising edge.
  task automatic sample();
    logic [1:0]  exp_rdy;
    logic        win, gid;
    logic [64:0] e;
    lo_v  = out_valid;
    lo_z  = out_z;
    lo_id = out_id;
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    win = (req_valid == 2'b11) ? ptr_m : req_valid[1];
    exp_rdy = '0;
    if ((|req_valid) && (!out_valid || out_ready || exp_q.size() < 2)) exp_rdy[win] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (hold_valid) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_z", out_z, hold_z);
      check("hold_id", 64'(out_id), 64'(hold_id));
    end
    if (out_valid) begin
      if (exp_q.size() == 0) check("stale_out", 64'd1, 64'd0);
      else if (out_ready) begin
        e = exp_q.pop_front();
        check("out_z", out_z, e[63:0]);
        check("out_id", 64'(out_id), 64'(e[64]));
      end
    end
    hold_valid = out_valid && !out_ready;
    hold_z     = out_z;
    hold_id    = out_id;
    acc = req_valid & req_ready;
    if (|acc) begin
      gid = acc[1];
      exp_q.push_back({gid, ref_mul(req_x[gid], req_y[gid], req_exact[gid])});
      ptr_m = ~gid;
      n_acc++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    req_x[i] = $urandom;
    req_y[i] = $urandom;
    if ($urandom_range(0, 3) == 0) req_x[i] = req_x[i] | 32'hF;
    if ($urandom_range(0, 3) == 0) req_y[i] = req_y[i] | 32'h6C00;
    if ($urandom_range(0, 7) == 0) req_x[i] = req_x[i] & 32'h3FF;
    req_exact[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_z", out_z, 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    ptr_m = 1'b0;
    hold_valid = 1'b0;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() != 0 || busy); k++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic issue_one(input int id, input logic [31:0] x, input logic [31:0] y,
                           input logic ex, input logic [63:0] exp_z);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_x[id] = x;
    req_y[id] = y;
    req_exact[id] = ex;
    out_ready = 1'b1;
    cycle();
    check("one_grant", 64'(acc), 64'(2'b01 << id));
    req_valid = '0;
    req_exact[id] = ~ex;
    cycle();
    check("lat_n1_valid", 64'(lo_v), 64'd0);
    cycle();
    check("lat_n2_valid", 64'(lo_v), 64'd1);
    check("lat_n2_z", lo_z, exp_z);
    check("lat_n2_id", 64'(lo_id), 64'(id));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      req_x[i] = '0;
      req_y[i] = '0;
    end
    do_reset();

    // First transaction right after reset release, then the worked examples.
    issue_one(0, 32'h400, 32'd3, 1'b0, 64'hC00);
    issue_one(1, 32'd3, 32'hC00, 1'b0, 64'h800);
    issue_one(1, 32'd3, 32'hC00, 1'b1, 64'h2400);
    drain();

    // Both requesters valid continuously: strict alternation starting at 0.
    do_reset();
    rand_ops(0);
    rand_ops(1);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_grant", 64'(acc), (k % 2 == 1) ? 64'd2 : 64'd1);
      for (int i = 0; i < 2; i++) if (acc[i]) rand_ops(i);
    end
    drain();

    // Output stalled for 5 cycles: only two transactions fit.
    rand_ops(0);
    rand_ops(1);
    req_valid = 2'b11;
    out_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      cnt += $countones(acc);
      for (int i = 0; i < 2; i++) if (acc[i]) rand_ops(i);
    end
    check("stall_accepts", 64'(cnt), 64'd2);
    drain();

    // Reset with both stages full drops everything.
    rand_ops(0);
    rand_ops(1);
    req_valid = 2'b11;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) if (acc[i]) rand_ops(i);
    end
    check("full_before_rst", 64'(exp_q.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    ptr_m = 1'b0;
    hold_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("post_rst_grant", 64'(acc), 64'd1);
    drain();

    // Long randomized run with random backpressure and mode.
    n_acc = 0;
    cyc = 0;
    rand_ops(0);
    rand_ops(1);
    req_valid = 2'b11;
    while (n_acc < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid[i]) begin
          rand_ops(i);
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
    end
    check("rand_count", 64'(n_acc), 64'd10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/approx_mul_arbiter.md
APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 Parameter TRUNC, default 10: number of low x bits dropped by the approximate product.
REQ-002 Parameter NREQ, default 2, fixed at 2: number of requester ports.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester operand valid.
REQ-006 req_ready  output  2  per-requester operand accepted this cycle when high together with req_valid.
REQ-007 req_x0, req_y0, req_x1, req_y1  input  32 each  unsigned operands of requester 0 and requester 1.
REQ-008 req_exact  input  2  per-requester mode: 1 = exact product, 0 = approximate product.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_z  output  64  product.
REQ-012 out_id  output  1  index of the requester that owns out_z.
REQ-013 busy  output  1  high while either pipeline stage holds a transaction.

Function
REQ-014 Approximate product: z = ((y * x[31:TRUNC]) << TRUNC) + C.
REQ-015 Compensation term C sets bit 11 if x[0]&x[1]&y[10]&y[11], and bit 17 if x[2]&x[3]&y[13]&y[14]; all other bits of C are 0.
REQ-016 Exact product: z = x*y with full 64-bit width and no truncation.
REQ-017 Pipeline has two stages: S1 holds operands, mode and id; S2 holds the registered product and id.
REQ-018 S1 may load when it is empty, or when S1 advances into S2 in the same cycle.
REQ-019 S2 may load when it is empty, or when out_valid&out_ready holds in the same cycle.
REQ-020 Latency with no backpressure: a grant in cycle N produces out_valid in cycle N+2.
REQ-021 Throughput with no backpressure: one result per cycle.
REQ-022 Arbitration is round-robin with a 1-bit priority pointer.
REQ-023 If only one requester is valid, that requester wins; if both are valid, the requester named by the pointer wins.
REQ-024 After each grant the pointer moves to the non-granted requester; it does not change when no grant occurs.
REQ-025 req_ready is high only for the winning requester, and only when S1 can load in that cycle; req_ready is a combinational function of req_valid, the pointer and pipeline state.
REQ-026 A granted transaction is never dropped or duplicated.
REQ-027 While out_valid=1 and out_ready=0, out_z and out_id stay stable and no req_ready is asserted once both stages are full.
REQ-028 Mode is sampled per transaction at grant; changing req_exact later does not affect a granted transaction.
REQ-029 busy = S1 occupied OR S2 occupied.

Reset
REQ-030 While rst_n=0 (asynchronous assertion): both stages are empty, the pointer is 0, and out_valid=0, out_z=0, out_id=0, busy=0, req_ready=0.
REQ-031 Reset asserted mid-operation discards all in-flight transactions without emitting them.
REQ-032 The first grant is possible in the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package holds TRUNC_DEFAULT, the compensation bit positions (11, 17) and the stage-valid record type.
REQ-034 Product arithmetic sits in one combinational sub-module, approx_mul32_core (inputs x, y, exact; output z), instantiated once between S1 and S2.
REQ-035 The arbiter and pipeline control sit in approx_mul_arbiter.

Verification
REQ-036 Requester 0 sends x=0x400, y=3, approximate -> out_z=0xC00, out_id=0, two cycles after grant.
REQ-037 Requester 1 sends x=3, y=0xC00, approximate -> out_z=0x800; the same operands with exact mode -> out_z=0x2400.
REQ-038 Both requesters valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1 and out_id follows the same order.
REQ-039 out_ready held 0 for 5 cycles with both requesters valid -> exactly 2 transactions accepted, out_z stable; on release, results drain in order with no loss.
REQ-040 rst_n pulsed low with both stages full -> out_valid=0 immediately, the pointer returns to 0, and no stale result appears after release.
REQ-041 Random operands over 10k transactions in both modes -> every result matches a reference model of REQ-014 to REQ-016, with the correct out_id.
